div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 152 +++++++++++++++
 tb/tb_div.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- 32-bit signed restoring divider, one quotient bit per clock.
//
// Ports:
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low reset
//   ctrl_DIV     in   1   start pulse; captures dividend/divisor, aborts any
//                         operation in flight
//   dividend     in  32   signed dividend (sampled on the start edge only)
//   divisor      in  32   signed divisor  (sampled on the start edge only)
//   result       out 32   signed quotient, truncated toward zero
//   exception    out  1   divide-by-zero flag, meaningful while resultReady=1
//   resultReady  out  1   one-cycle completion pulse
//   busy         out  1   high while an operation is in progress
//
// A nonzero-divisor operation takes 32 RUN edges plus one FIX edge, so
// resultReady rises after the 33rd edge following the start edge. A zero
// divisor skips straight to DONE on the start edge.
// -----------------------------------------------------------------------------
module div (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_DIV,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] result,
  output logic        exception,
  output logic        resultReady,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q,     state_d;
  logic [5:0]  cnt_q,       cnt_d;
  logic [31:0] rem_q,       rem_d;
  logic [31:0] quo_q,       quo_d;
  logic [32:0] dsr_q,       dsr_d;
  logic        sign_q,      sign_d;
  logic [31:0] result_q,    result_d;
  logic        exception_q, exception_d;

  logic [31:0] abs_dividend;
  logic [31:0] abs_divisor;
  logic [32:0] shifted;
  logic [32:0] trial;

  // Magnitudes are kept unsigned, so -0x80000000 wraps back to 0x80000000,
  // which is exactly the correct magnitude when read as unsigned.
  always_comb begin
    abs_dividend = dividend[31] ? (32'd0 - dividend) : dividend;
    abs_divisor  = divisor[31]  ? (32'd0 - divisor)  : divisor;
  end

  // One restoring step. The partial remainder is always below the divisor
  // magnitude (<= 2^31), so it fits in 32 bits and the shifted value fits in
  // 33; bit 32 of the 33-bit trial difference is therefore a valid sign bit.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - dsr_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    sign_d      = sign_q;
    result_d    = result_q;
    exception_d = exception_q;

    // A start wins over whatever state we are in. The outputs are only
    // written on completion, so an aborted operation never becomes visible.
    if (ctrl_DIV) begin
      cnt_d = 6'd0;
      rem_d = 32'd0;
      if (divisor == 32'd0) begin
        state_d     = DONE;
        quo_d       = 32'd0;
        dsr_d       = 33'd0;
        sign_d      = 1'b0;
        result_d    = 32'd0;
        exception_d = 1'b1;
      end else begin
        state_d = RUN;
        quo_d   = abs_dividend;
        dsr_d   = {1'b0, abs_divisor};
        sign_d  = dividend[31] ^ divisor[31];
      end
    end else begin
      case (state_q)
        RUN: begin
          if (trial[32]) begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end else begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = FIX;
          end
        end
        FIX: begin
          result_d    = sign_q ? (32'd0 - quo_q) : quo_q;
          exception_d = 1'b0;
          state_d     = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dsr_q       <= 33'd0;
      sign_q      <= 1'b0;
      result_q    <= 32'd0;
      exception_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      exception_q <= exception_d;
    end
  end

  // resultReady and busy are pure decodes of the registered state.
  assign result      = result_q;
  assign exception   = exception_q;
  assign resultReady = (state_q == DONE);
  assign busy        = (state_q == RUN) || (state_q == FIX);

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div -- self-checking bench for div.
// Table-driven divisions followed by hand-written restart and mid-run reset
// sequences. Inputs change and outputs are sampled 1 ns after a rising edge.
// -----------------------------------------------------------------------------
module tb_div;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] result;
  logic        exception;
  logic        resultReady;
  logic        busy;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic [31:0] dd;
    logic [31:0] ds;
    logic [31:0] res;
    logic        exc;
    int          lat;
    int          busyCycles;
  } vec_t;

  vec_t vecs[12];

  div dut (
    .clock       (clock),
    .reset       (reset),
    .ctrl_DIV    (ctrl_DIV),
    .dividend    (dividend),
    .divisor     (divisor),
    .result      (result),
    .exception   (exception),
    .resultReady (resultReady),
    .busy        (busy)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one value against its expectation and keep the tallies
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present a start pulse, then watch 40 edges starting with the start edge.
  // Edge index 0 is the start edge. Operands are scrambled right after the
  // start edge so any late sampling would show up as a wrong quotient.
  task automatic applyStimulus(input logic [31:0] dd, input logic [31:0] ds,
                               output int lat, output int pulses,
                               output int busyCycles);
    lat        = -1;
    pulses     = 0;
    busyCycles = 0;
    dividend   = dd;
    divisor    = ds;
    ctrl_DIV   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (i == 0) begin
        ctrl_DIV = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
      end
      if (busy) busyCycles++;
      if (resultReady) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int busyCycles;
    logic [31:0] held;

    nCompared   = 0;
    nMismatched = 0;

    vecs[0]  = '{32'd100,       32'd7,          32'd14,         1'b0, 33, 33};
    vecs[1]  = '{-32'sd100,     32'd7,          32'hFFFFFFF2,   1'b0, 33, 33};
    vecs[2]  = '{32'd100,       -32'sd7,        32'hFFFFFFF2,   1'b0, 33, 33};
    vecs[3]  = '{-32'sd100,     -32'sd7,        32'd14,         1'b0, 33, 33};
    vecs[4]  = '{32'd6,         32'd7,          32'd0,          1'b0, 33, 33};
    vecs[5]  = '{32'd7,         32'd7,          32'd1,          1'b0, 33, 33};
    vecs[6]  = '{32'd1234,      32'd0,          32'd0,          1'b1, 0,  0};
    vecs[7]  = '{32'd5,         32'd5,          32'd1,          1'b0, 33, 33};
    vecs[8]  = '{32'h80000000,  32'hFFFFFFFF,   32'h80000000,   1'b0, 33, 33};
    vecs[9]  = '{32'h80000000,  32'd1,          32'h80000000,   1'b0, 33, 33};
    vecs[10] = '{-32'sd7,       32'd2,          32'hFFFFFFFD,   1'b0, 33, 33};
    vecs[11] = '{32'h7FFFFFFF,  32'd2,          32'h3FFFFFFF,   1'b0, 33, 33};

    // Reset state
    ctrl_DIV = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    reset    = 1'b0;
    #12;
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_exception", {31'd0, exception}, 32'd0);
    checkOutput("reset_ready", {31'd0, resultReady}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Table-driven divisions
    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].dd, vecs[v].ds, lat, pulses, busyCycles);
      $display("[TB] vector %0d: 0x%08h / 0x%08h", v, vecs[v].dd, vecs[v].ds);
      checkOutput("result", result, vecs[v].res);
      checkOutput("exception", {31'd0, exception}, {31'd0, vecs[v].exc});
      checkOutput("latency", lat, vecs[v].lat);
      checkOutput("ready_pulses", pulses, 32'd1);
      checkOutput("busy_cycles", busyCycles, vecs[v].busyCycles);
    end

    // Restart: 1000/3 aborted at edge 10 by 50/5
    held     = result;
    dividend = 32'd1000;
    divisor  = 32'd3;
    ctrl_DIV = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (i == 0) ctrl_DIV = 1'b0;
      if (resultReady) pulses++;
    end
    checkOutput("restart_hold_result", result, held);
    applyStimulus(32'd50, 32'd5, lat, pulses, busyCycles);
    checkOutput("restart_result", result, 32'd10);
    checkOutput("restart_latency", lat, 32'd33);
    checkOutput("restart_pulses", pulses, 32'd1);

    // Reset mid-run: 1000/3, reset low after edge 15
    dividend = 32'd1000;
    divisor  = 32'd3;
    ctrl_DIV = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock);
      #1;
      if (i == 0) ctrl_DIV = 1'b0;
    end
    checkOutput("midrun_busy_before", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrun_reset_result", result, 32'd0);
    checkOutput("midrun_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrun_reset_ready", {31'd0, resultReady}, 32'd0);
    @(posedge clock);
    #1;
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (resultReady) pulses++;
    end
    checkOutput("after_reset_no_ready", pulses, 32'd0);
    checkOutput("after_reset_idle_busy", {31'd0, busy}, 32'd0);
    applyStimulus(32'd9, 32'd3, lat, pulses, busyCycles);
    checkOutput("after_reset_result", result, 32'd3);
    checkOutput("after_reset_latency", lat, 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
